// File: rtl/bw_io_dtl_pkg.sv
// Shared types and constants for the DTL receiver boundary-scan control slice.
// PARITY state exists only when BW_IO_DTL_BSCAN_PARITY_EN is defined.
package bw_io_dtl_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SHIFT,
`ifdef BW_IO_DTL_BSCAN_PARITY_EN
    PARITY,
`endif
    DONE
  } bscan_state_e;

endpackage

// File: rtl/bw_io_dtl_sync2.sv
// WIDTH-wide multi-flop synchronizer (depth SYNC_STAGES) with synchronous
// active-high clear.
module bw_io_dtl_sync2
  import bw_io_dtl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/bw_io_dtl_bscan_ctl.sv
// Boundary-scan capture-and-shift controller for DTL receiver outputs.
// Optional trailing even-parity bit when BW_IO_DTL_BSCAN_PARITY_EN is defined.
module bw_io_dtl_bscan_ctl
  import bw_io_dtl_pkg::*;
#(
  parameter int unsigned NUM_RCV = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_RCV-1:0] rcv_so,
  input  logic               bs_start,
  input  logic               bs_sdi,
  output logic               bs_busy,
  output logic               bs_sdo,
  output logic               bs_sdo_vld,
  output logic               bs_done,
  output logic [NUM_RCV-1:0] cap_data
);

  localparam int unsigned CW = $clog2(NUM_RCV);

  bscan_state_e     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NUM_RCV-1:0] shreg_q, shreg_d;
  logic [NUM_RCV-1:0] cap_q, cap_d;
  logic [NUM_RCV-1:0] rcv_sync;
  logic busy_q, busy_d;
  logic sdo_q, sdo_d;
  logic vld_q, vld_d;
  logic done_q, done_d;

  bw_io_dtl_sync2 #(.WIDTH(NUM_RCV)) u_sync (
    .clk_i (clk),
    .clr_i (rst),
    .d_i   (rcv_so),
    .q_o   (rcv_sync)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    cap_d   = cap_q;
    case (state_q)
      IDLE:    if (bs_start) state_d = CAPTURE;
      CAPTURE: begin
        state_d = SHIFT;
        shreg_d = rcv_sync;
        cap_d   = rcv_sync;
        cnt_d   = '0;
      end
      SHIFT: begin
        shreg_d = {bs_sdi, shreg_q[NUM_RCV-1:1]};
        if (cnt_q == CW'(NUM_RCV - 1)) begin
`ifdef BW_IO_DTL_BSCAN_PARITY_EN
          state_d = PARITY;
`else
          state_d = DONE;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef BW_IO_DTL_BSCAN_PARITY_EN
      PARITY:  state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with the state.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    sdo_d  = 1'b0;
    vld_d  = 1'b0;
    if (state_d == SHIFT) begin
      sdo_d = shreg_d[0];
      vld_d = 1'b1;
    end
`ifdef BW_IO_DTL_BSCAN_PARITY_EN
    if (state_d == PARITY) begin
      sdo_d = ^cap_d;
      vld_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      cap_q   <= '0;
      busy_q  <= 1'b0;
      sdo_q   <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      cap_q   <= cap_d;
      busy_q  <= busy_d;
      sdo_q   <= sdo_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign bs_busy    = busy_q;
  assign bs_sdo     = sdo_q;
  assign bs_sdo_vld = vld_q;
  assign bs_done    = done_q;
  assign cap_data   = cap_q;

endmodule

// File: tb/tb_bw_io_dtl_bscan_ctl.sv
// Directed bench for bw_io_dtl_bscan_ctl; expectations adapt to
// BW_IO_DTL_BSCAN_PARITY_EN.
module tb_bw_io_dtl_bscan_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rcv_so = '0;
  logic        bs_start = 1'b0;
  logic        bs_sdi = 1'b0;
  logic        bs_busy, bs_sdo, bs_sdo_vld, bs_done;
  logic [15:0] cap_data;

  int vecs = 0;
  int errs = 0;

`ifdef BW_IO_DTL_BSCAN_PARITY_EN
  localparam int DONE_CYC = 19;
`else
  localparam int DONE_CYC = 18;
`endif

  bw_io_dtl_bscan_ctl #(.NUM_RCV(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rcv_so     (rcv_so),
    .bs_start   (bs_start),
    .bs_sdi     (bs_sdi),
    .bs_busy    (bs_busy),
    .bs_sdo     (bs_sdo),
    .bs_sdo_vld (bs_sdo_vld),
    .bs_done    (bs_done),
    .cap_data   (cap_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [15:0] v);
    rcv_so = v;
    repeat (3) tick();
  endtask

  // Start pulse crosses edge 0; checks cycle 1 .. first IDLE cycle after DONE.
  task automatic run_sequence(input string name, input logic [15:0] exp_bits,
                              input logic [15:0] exp_cap, input logic exp_par,
                              input logic late, input logic [15:0] late_val);
    bs_start = 1'b1;
    tick();
    bs_start = 1'b0;
    if (late) rcv_so = late_val;
    vecs++;
    if (bs_busy !== 1'b1 || bs_sdo_vld !== 1'b0 || bs_done !== 1'b0) begin
      errs++;
      $display("FAIL %s capture: busy=%b vld=%b done=%b, want 1 0 0", name, bs_busy, bs_sdo_vld, bs_done);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      vecs++;
      if (bs_sdo !== exp_bits[i] || bs_sdo_vld !== 1'b1 || bs_done !== 1'b0) begin
        errs++;
        $display("FAIL %s shift bit %0d: sdo=%b vld=%b done=%b, want %b 1 0",
                 name, i, bs_sdo, bs_sdo_vld, bs_done, exp_bits[i]);
      end
    end
    tick();
`ifdef BW_IO_DTL_BSCAN_PARITY_EN
    vecs++;
    if (bs_sdo !== exp_par || bs_sdo_vld !== 1'b1 || bs_done !== 1'b0) begin
      errs++;
      $display("FAIL %s parity: sdo=%b vld=%b done=%b, want %b 1 0", name, bs_sdo, bs_sdo_vld, bs_done, exp_par);
    end
    tick();
`else
    if (exp_par === 1'bx) $display("note: parity arg unused");
`endif
    vecs++;
    if (bs_done !== 1'b1 || bs_sdo_vld !== 1'b0 || bs_sdo !== 1'b0 || bs_busy !== 1'b1) begin
      errs++;
      $display("FAIL %s done: done=%b vld=%b sdo=%b busy=%b, want 1 0 0 1", name, bs_done, bs_sdo_vld, bs_sdo, bs_busy);
    end
    tick();
    vecs++;
    if (bs_busy !== 1'b0 || bs_done !== 1'b0 || cap_data !== exp_cap) begin
      errs++;
      $display("FAIL %s idle: busy=%b done=%b cap=%h, want 0 0 %h", name, bs_busy, bs_done, cap_data, exp_cap);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rcv_so = 16'hFFFF;
    bs_start = 1'b1;
    repeat (3) tick();
    vecs++;
    if ({bs_busy, bs_sdo, bs_sdo_vld, bs_done} !== 4'b0000 || cap_data !== 16'h0000) begin
      errs++;
      $display("FAIL reset_state: outs=%b cap=%h, want 0000 0000", {bs_busy, bs_sdo, bs_sdo_vld, bs_done}, cap_data);
    end
    bs_start = 1'b0;
    rst = 1'b0;
    tick();
    vecs++;
    if (bs_busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: busy=%b, want 0", bs_busy);
    end
  endtask

  task automatic test_pattern_a5c3();
    settle(16'hA5C3);
    // A5C3 LSB first: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 ; eight ones -> parity 0
    run_sequence("a5c3", 16'hA5C3, 16'hA5C3, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_parity_one();
    settle(16'h0001);
    run_sequence("single_one", 16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic test_sdi_reload();
    bs_sdi = 1'b1;
    settle(16'h0F0F);
    run_sequence("sdi_fill", 16'h0F0F, 16'h0F0F, 1'b0, 1'b0, 16'h0);
    settle(16'h0000);
    run_sequence("reload", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0);
    bs_sdi = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_busy, exp_done;
    settle(16'h3C3C);
    bs_start = 1'b1;
    // Cycle c after edge 0: busy 1..D, idle at D+1, second run D+2..2D+1, idle 2D+2.
    for (int c = 1; c <= 2 * DONE_CYC + 2; c++) begin
      tick();
      if (c == 2 * DONE_CYC + 1) bs_start = 1'b0;
      exp_busy = (c != DONE_CYC + 1) && (c != 2 * DONE_CYC + 2);
      exp_done = (c == DONE_CYC) || (c == 2 * DONE_CYC + 1);
      vecs++;
      if (bs_busy !== exp_busy || bs_done !== exp_done) begin
        errs++;
        $display("FAIL back_to_back cycle %0d: busy=%b done=%b, want %b %b", c, bs_busy, bs_done, exp_busy, exp_done);
      end
    end
    bs_start = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_shift();
    int seen_bad;
    settle(16'hFFFF);
    bs_start = 1'b1;
    tick();
    bs_start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if ({bs_busy, bs_sdo, bs_sdo_vld, bs_done} !== 4'b0000 || cap_data !== 16'h0000) begin
      errs++;
      $display("FAIL mid_reset: outs=%b cap=%h, want 0000 0000", {bs_busy, bs_sdo, bs_sdo_vld, bs_done}, cap_data);
    end
    seen_bad = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (bs_done !== 1'b0 || bs_sdo_vld !== 1'b0 || bs_busy !== 1'b0) seen_bad++;
    end
    vecs++;
    if (seen_bad != 0) begin
      errs++;
      $display("FAIL mid_reset_quiet: %0d active cycles after abort, want 0", seen_bad);
    end
    rst = 1'b1;
    bs_start = 1'b1;
    tick();
    rst = 1'b0;
    bs_start = 1'b0;
    tick();
    vecs++;
    if (bs_busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_over_start: busy=%b, want 0", bs_busy);
    end
  endtask

  task automatic test_sync_latency();
    settle(16'h1111);
    // rcv_so switches to 2222 after edge 0; capture edge 1 must still see 1111
    run_sequence("sync_latency", 16'h1111, 16'h1111, 1'b0, 1'b1, 16'h2222);
  endtask

  initial begin
    test_reset();
    test_pattern_a5c3();
    test_parity_one();
    test_sdi_reload();
    test_back_to_back();
    test_reset_mid_shift();
    test_sync_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bw_io_dtl_bscan_ctl.md
BW_IO_DTL_BSCAN_CTL -- requirements
Module: bw_io_dtl_bscan_ctl

Interface
REQ-001 SHALL provide parameter NUM_RCV, default 16, the number of DTL receiver DC outputs under boundary-scan control; legal range 2..64.
REQ-002 SHALL provide port clk, input, 1, the single block clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-004 SHALL provide port rcv_so, input, NUM_RCV: asynchronous receiver outputs (pad level).
REQ-005 SHALL provide port bs_start, input, 1: request one capture-and-shift sequence.
REQ-006 SHALL provide port bs_sdi, input, 1: serial scan-in, fills the chain behind shifted-out data.
REQ-007 SHALL provide port bs_busy, output, 1: sequence in progress.
REQ-008 SHALL provide port bs_sdo, output, 1: serial scan-out data.
REQ-009 SHALL provide port bs_sdo_vld, output, 1: bs_sdo carries a valid bit this cycle.
REQ-010 SHALL provide port bs_done, output, 1: one-cycle end-of-sequence pulse.
REQ-011 SHALL provide port cap_data, output, NUM_RCV: parallel copy of the last captured vector.

Function
REQ-012 SHALL pass rcv_so through a 2-flop synchronizer per bit before any use.
REQ-013 SHALL implement FSM states IDLE, CAPTURE, SHIFT, PARITY, DONE.
REQ-014 SHALL leave IDLE for CAPTURE only on an edge with bs_start=1; bs_start SHALL be ignored in every other state, with no queuing.
REQ-015 SHALL, at the CAPTURE->SHIFT edge, load the shift register and cap_data with the synchronized vector and clear the bit counter.
REQ-016 SHALL, in SHIFT, drive bs_sdo=shreg[0] and bs_sdo_vld=1, and shift right each edge with bs_sdi entering shreg[NUM_RCV-1].
REQ-017 SHALL leave SHIFT after exactly NUM_RCV cycles; the counter is $clog2(NUM_RCV) bits and never wraps within one sequence.
REQ-018 SHALL, in PARITY (only when compiled in), drive bs_sdo=even parity (XOR) of cap_data and bs_sdo_vld=1 for one cycle.
REQ-019 SHALL assert bs_done for exactly one cycle in DONE, then return to IDLE.
REQ-020 SHALL hold bs_busy=1 in CAPTURE, SHIFT, PARITY and DONE, and 0 in IDLE.
REQ-021 SHALL hold bs_sdo=0 and bs_sdo_vld=0 outside SHIFT and PARITY.
REQ-022 SHALL accept bs_start in the cycle directly after DONE, giving back-to-back sequences with one IDLE cycle between them.
REQ-023 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, force state IDLE, counter 0, shreg 0, cap_data 0, synchronizer flops 0, and all outputs 0.
REQ-025 SHALL abort a sequence on reset mid-operation, with no bs_done pulse and no further bs_sdo_vld.
REQ-026 SHALL let rst override bs_start on the same edge.

Configuration
REQ-027 SHALL compile in the PARITY state and trailing parity bit only when macro BW_IO_DTL_BSCAN_PARITY_EN is defined; without it, SHIFT SHALL go directly to DONE and PARITY SHALL be unreachable and absent.

Structure
REQ-028 SHALL take the FSM state enum and the synchronizer depth constant from shared package bw_io_dtl_pkg.
REQ-029 SHALL instantiate sub-module bw_io_dtl_sync2, a NUM_RCV-wide 2-flop synchronizer with synchronous active-high clear, for REQ-012.

Verification
REQ-030 SHALL check: NUM_RCV=16, rcv_so=16'hA5C3 stable, bs_start pulsed at edge 0 -> CAPTURE in cycle 1, bs_sdo 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 in cycles 2-17, bs_done in cycle 18 (cycle 19 with parity, parity bit 0).
REQ-031 SHALL check: macro defined, rcv_so=16'h0001 -> cycle 18 bs_sdo=1 with bs_sdo_vld=1, bs_done in cycle 19.
REQ-032 SHALL check: bs_sdi=1 throughout one sequence, then a second sequence with rcv_so=0 -> cap_data=16'h0000 on the second sequence, proving a reload rather than residual 1s.
REQ-033 SHALL check: bs_start held high continuously -> sequences separated by exactly one IDLE cycle, and no start accepted while busy.
REQ-034 SHALL check: rst asserted in cycle 8 of SHIFT -> next cycle all outputs 0, state IDLE, and no bs_done pulse.
REQ-035 SHALL check: rcv_so changed one cycle before the CAPTURE edge -> cap_data holds the old value (2-flop latency).
